seg7_scan: RTL

//  Time-multiplexed driver for the board's 4-digit common-anode 7-segment display.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_hexdec.sv | 11 +
 rtl/seg7_scan.sv | 102 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver: blank/off codes,
// the hex-to-segment table (gfedcba, active low) and the idx-to-anode decode.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Entry n is the active-low pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // One-cold anode select: only the addressed digit's anode is pulled low.
  function automatic logic [3:0] an_decode(input logic [1:0] idx);
    logic [3:0] sel;
    sel = 4'b0001 << idx;
    return ~sel;
  endfunction

endpackage

// File: rtl/seg7_hexdec.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A shadow register holds the displayed value; one digit is lit per
// SCAN_DIV-cycle slot, outputs registered one cycle after (idx, shadow).
// Optional feature: define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_shadow_val;
  logic [3:0]       r_shadow_dp;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp_n;

  logic             w_tick;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg_dec;
  logic [6:0]       w_seg_next;

  assign w_tick = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_nib  = r_shadow_val[{r_idx, 2'b00} +: 4];

  // Prescaler: one tick per digit slot.
  always_ff @(posedge clk) begin
    if (rst)         r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + 1'b1;
  end

  // Digit ring counter 0,1,2,3,0... advancing on tick.
  always_ff @(posedge clk) begin
    if (rst)         r_idx <= 2'd0;
    else if (w_tick) r_idx <= r_idx + 2'd1;
  end

  // Shadow capture, independent of the scan phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_val <= 16'h0000;
      r_shadow_dp  <= 4'b0000;
    end else if (load) begin
      r_shadow_val <= value;
      r_shadow_dp  <= dp;
    end
  end

  seg7_hexdec u_hexdec (
    .i_nib (w_nib),
    .o_seg (w_seg_dec)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic w_blank;

  // Blank a digit when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd3:    w_blank = (r_shadow_val[15:12] == 4'h0);
      2'd2:    w_blank = (r_shadow_val[15:8]  == 8'h00);
      2'd1:    w_blank = (r_shadow_val[15:4]  == 12'h000);
      default: w_blank = 1'b0;
    endcase
  end

  assign w_seg_next = w_blank ? SEG_BLANK : w_seg_dec;
`else
  assign w_seg_next = w_seg_dec;
`endif

  // Registered outputs: anode and segments move on the same edge, so no ghosting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an   <= AN_OFF;
      r_seg  <= SEG_BLANK;
      r_dp_n <= 1'b1;
    end else begin
      r_an   <= an_decode(r_idx);
      r_seg  <= w_seg_next;
      r_dp_n <= ~r_shadow_dp[r_idx];
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp_n = r_dp_n;

endmodule
